// File: rtl/sap_core_param.sv
// sap_core_param: parametrised single-bus teaching CPU core with A/B registers, ALU with flags,
// PC, IR, MAR, program/data RAM and a fixed five-step micro-sequencer.
// DATA_W must be at least 4 + ADDR_W so that the opcode and operand fields do not overlap.
module sap_core_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_en,
  input  logic              advance,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted,
  output logic              zf,
  output logic              cf,
  output logic [DATA_W-1:0] bus_dbg,
  output logic [ADDR_W-1:0] pc_dbg
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PcOne = {{(ADDR_W-1){1'b0}}, 1'b1};

  localparam logic [3:0] OpLda = 4'h1;
  localparam logic [3:0] OpAdd = 4'h2;
  localparam logic [3:0] OpSub = 4'h3;
  localparam logic [3:0] OpSta = 4'h4;
  localparam logic [3:0] OpLdi = 4'h5;
  localparam logic [3:0] OpJmp = 4'h6;
  localparam logic [3:0] OpJc  = 4'h7;
  localparam logic [3:0] OpJz  = 4'h8;
  localparam logic [3:0] OpOut = 4'hE;
  localparam logic [3:0] OpHlt = 4'hF;

  typedef enum logic [2:0] {StT0, StT1, StT2, StT3, StT4} step_e;

  step_e             step_q;
  logic [ADDR_W-1:0] pc_q, mar_q;
  logic [DATA_W-1:0] a_q, b_q, ir_q, out_data_q;
  logic              out_valid_q, halted_q, zf_q, cf_q;
  logic [DATA_W-1:0] mem_q [Depth];

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] operand_ext, pc_ext, mem_rd;
  logic              adv, is_sub;
  logic [DATA_W-1:0] alu_b, alu_res;
  logic [DATA_W:0]   alu_sum;
  logic [DATA_W-1:0] bus;

  assign opcode      = ir_q[DATA_W-1 -: 4];
  assign operand     = ir_q[ADDR_W-1:0];
  assign operand_ext = {{(DATA_W-ADDR_W){1'b0}}, operand};
  assign pc_ext      = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
  assign mem_rd      = mem_q[mar_q];

  // A micro-step is taken when running free or on an advance pulse; HLT freezes everything.
  assign adv = ~halted_q & (~step_en | advance);

  // SUB is A + ~B + 1, so the carry out doubles as "no borrow".
  assign is_sub  = (opcode == OpSub);
  assign alu_b   = is_sub ? ~b_q : b_q;
  assign alu_sum = {1'b0, a_q} + {1'b0, alu_b} + {{DATA_W{1'b0}}, is_sub};
  assign alu_res = alu_sum[DATA_W-1:0];

  // RAM: program load only under reset, STA writes only while running (reset aborts the store).
  always_ff @(posedge clk) begin
    if (rst) begin
      if (prog_we) begin
        mem_q[prog_addr] <= prog_data;
      end
    end else if (adv && step_q == StT3 && opcode == OpSta) begin
      mem_q[mar_q] <= a_q;
    end
  end

  // Micro-sequencer and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_q      <= StT0;
      pc_q        <= '0;
      mar_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      ir_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      zf_q        <= 1'b0;
      cf_q        <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (adv) begin
        unique case (step_q)
          StT0: begin
            mar_q  <= pc_q;
            step_q <= StT1;
          end
          StT1: begin
            ir_q   <= mem_rd;
            pc_q   <= pc_q + PcOne;
            step_q <= StT2;
          end
          StT2: begin
            step_q <= StT3;
            case (opcode)
              OpLda, OpAdd, OpSub, OpSta: mar_q <= operand;
              OpLdi: a_q <= operand_ext;
              OpJmp: pc_q <= operand;
              OpJc:  if (cf_q) pc_q <= operand;
              OpJz:  if (zf_q) pc_q <= operand;
              OpOut: begin
                out_data_q  <= a_q;
                out_valid_q <= 1'b1;
              end
              OpHlt: halted_q <= 1'b1;
              default: ;
            endcase
          end
          StT3: begin
            step_q <= StT4;
            case (opcode)
              OpLda:        a_q <= mem_rd;
              OpAdd, OpSub: b_q <= mem_rd;
              default: ;
            endcase
          end
          StT4: begin
            step_q <= StT0;
            if (opcode == OpAdd || opcode == OpSub) begin
              a_q  <= alu_res;
              cf_q <= alu_sum[DATA_W];
              zf_q <= (alu_res == '0);
            end
          end
          default: step_q <= StT0;
        endcase
      end
    end
  end

  // Bus source for the current micro-step; zero when no unit drives it.
  always_comb begin
    bus = '0;
    unique case (step_q)
      StT0: bus = pc_ext;
      StT1: bus = mem_rd;
      StT2: begin
        case (opcode)
          OpLda, OpAdd, OpSub, OpSta, OpLdi, OpJmp: bus = operand_ext;
          OpJc:  if (cf_q) bus = operand_ext;
          OpJz:  if (zf_q) bus = operand_ext;
          OpOut: bus = a_q;
          default: ;
        endcase
      end
      StT3: begin
        case (opcode)
          OpLda, OpAdd, OpSub: bus = mem_rd;
          OpSta: bus = a_q;
          default: ;
        endcase
      end
      StT4: begin
        if (opcode == OpAdd || opcode == OpSub) bus = alu_res;
      end
      default: ;
    endcase
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign halted    = halted_q;
  assign zf        = zf_q;
  assign cf        = cf_q;
  assign bus_dbg   = bus;
  assign pc_dbg    = pc_q;

endmodule

// File: doc/sap_core_param.md
Name: sap_core_param

Overview:
- Parametrised successor to the 8-bit single-bus teaching CPU: one synthesizable core holding A/B registers, ALU with flags, PC, IR, MAR, program/data RAM and the microcode sequencer.
- Generalised data width and address width; adds conditional jumps (JC/JZ), immediate load, a registered output port with valid strobe, single-step mode and a program-load port.
- Sits under the board top; the display driver consumes out_data/out_valid.

Parameters:
- DATA_W, 8, datapath/RAM word width; must satisfy DATA_W >= 4 + ADDR_W.
- ADDR_W, 4, address width; RAM depth = 2**ADDR_W.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- step_en  in  1  1 = single-step mode
- advance  in  1  one-cycle pulse; advances one micro-step when step_en=1
- prog_we  in  1  RAM write strobe, honoured only while rst=1
- prog_addr  in  ADDR_W  program-load address
- prog_data  in  DATA_W  program-load data
- out_data  out  DATA_W  last value written by OUT
- out_valid  out  1  one-cycle strobe, new out_data
- halted  out  1  core stopped by HLT
- zf  out  1  zero flag
- cf  out  1  carry flag
- bus_dbg  out  DATA_W  value on internal bus this cycle (0 when undriven)
- pc_dbg  out  ADDR_W  current PC

Behaviour:
- Reset (rst=1 at edge): PC, A, B, IR, MAR, zf, cf, out_data, halted <= 0; out_valid <= 0; micro-step <= T0. RAM is not cleared; prog_we writes RAM[prog_addr] <= prog_data during reset. prog_we with rst=0 is ignored.
- Instruction word: opcode = bits [DATA_W-1 : DATA_W-4]; operand = bits [ADDR_W-1:0].
- Every instruction takes exactly 5 micro-steps T0..T4, then T0. Unused steps are idle.
- Fetch: T0 MAR <= PC. T1 IR <= RAM[MAR]; PC <= PC+1, wrapping 2**ADDR_W-1 -> 0.
- Execute (T2/T3/T4):
  - 0 NOP: idle.
  - 1 LDA a: MAR<=a / A<=RAM[MAR] / idle.
  - 2 ADD a: MAR<=a / B<=RAM[MAR] / A<=A+B, flags.
  - 3 SUB a: as ADD, but A<=A-B.
  - 4 STA a: MAR<=a / RAM[MAR]<=A / idle.
  - 5 LDI k: A<=zero-extended k.
  - 6 JMP a: PC<=a.
  - 7 JC a: PC<=a if cf=1.
  - 8 JZ a: PC<=a if zf=1.
  - E OUT: out_data<=A, out_valid high for the following cycle only.
  - F HLT: halted<=1.
  - Other opcodes execute as NOP.
- Flags are updated only by ADD and SUB, at their T4.
  - ADD: cf = carry out of bit DATA_W-1.
  - SUB: two's-complement A+~B+1; cf = carry out, so cf=1 iff A>=B unsigned.
  - zf = (DATA_W-bit result == 0). Result wraps mod 2**DATA_W.
- Taken branches use the flags present at their T2, i.e. the flags from the preceding ADD/SUB.
- Step mode: with step_en=1, the micro-step and all state advance only on cycles with advance=1; otherwise everything holds. out_valid still pulses one cycle. Toggling step_en mid-instruction resumes from the current micro-step.
- Halted: all state frozen and advance ignored; only rst clears it. zf, cf, out_data and pc_dbg remain readable.
- Bus: exactly one source drives it per micro-step (PC, RAM, A, IR operand, ALU); bus_dbg = 0 in idle steps.
- Reset mid-instruction aborts the instruction: there is no partial RAM write, and the core restarts at T0 with PC=0.

Test Plan:
- Load RAM[0..3] = LDA 14, ADD 15, OUT, HLT; RAM[14]=28, RAM[15]=14 (DATA_W=8, ADDR_W=4); release rst at cycle 0.
  -> out_valid high only in cycle 13 with out_data=42; halted=1 from cycle 18; zf=0, cf=0; state frozen thereafter.
- Same program but RAM[15]=228.
  -> out_data=0, zf=1, cf=1.
- SUB with RAM[14]=5, RAM[15]=7.
  -> out_data=254, cf=0, zf=0.
- Loop `LDI 3; SUB 15 (=1); JZ 5; JMP 1; HLT at 5; OUT at 4`.
  -> JZ not taken twice, taken on the third pass; halted with A=0; out_valid never asserted.
- step_en=1, advance pulsed every 4 cycles.
  -> PC increments once per 5 pulses; holding advance=0 for 100 cycles changes nothing; prog_we with rst=0 leaves RAM unchanged.
- Parameter sweep DATA_W=12, ADDR_W=8: JMP 255 from PC 254 followed by a fetch.
  -> PC wraps to 0; ADD 4095+1 gives A=0, cf=1, zf=1.
